// File: rtl/irq_pkg.sv
// Shared constants and types for the irq_wb priority interrupt controller.
// The RST n opcode is the 8'hC7 template with the level number in bits [5:3].
package irq_pkg;

  localparam logic       IRR_ADR  = 1'b0;
  localparam logic       EOI_ADR  = 1'b1;
  localparam logic [7:0] RST_TMPL = 8'hC7;
  localparam logic [7:0] IMR_RST  = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_st_e;

  function automatic logic [7:0] rst_op(input logic [2:0] n);
    return RST_TMPL | {2'b00, n, 3'b000};
  endfunction

endpackage

// File: rtl/irq_prio8.sv
// Lowest-index-wins priority encoder: bit 0 is the most urgent level.
module irq_prio8 (
  input  logic [7:0] i_vec,
  output logic       o_valid,
  output logic [2:0] o_idx
);

  // Scanning downward lets the lowest set bit overwrite higher ones.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_valid = 1'b1;
        o_idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_wb.sv
// Wishbone-slave priority interrupt controller for the vm80 i8080 system.
// Latches peripheral requests, raises vm_irq_o and answers INTA cycles with RST n.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for a register or interrupt-acknowledge strobe
//   ST_ACK  | wb_ack_o high for one cycle, data registered on entry
module irq_wb
  import irq_pkg::*;
#(
  parameter int NIRQ     = 8,
  parameter bit EDGE     = 1'b1,
  parameter int SPUR_VEC = 7
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            wb_adr_i,
  input  logic [7:0]      wb_dat_i,
  output logic [7:0]      wb_dat_o,
  input  logic            wb_cyc_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  input  logic            inta_stb_i,
  input  logic [NIRQ-1:0] irq_i,
  output logic            vm_irq_o
);

  localparam logic [7:0] VALID_MASK = 8'((9'h1 << NIRQ) - 9'h1);

  bus_st_e         r_state, w_state_nxt;
  logic [NIRQ-1:0] r_sync1, r_sync2, r_sync3;
  logic [7:0]      r_irr, r_imr, r_isr, r_dat;
  logic            r_irq;

  logic [7:0]      w_sync8, w_rise8, w_req, w_set8;
  logic [7:0]      w_irr_nxt, w_imr_nxt, w_isr_nxt, w_dat_nxt;
  logic            w_req_v, w_isr_v, w_elig;
  logic [2:0]      w_win, w_isr_idx;
  logic            w_commit, w_inta, w_wr, w_ack_set;

  assign w_sync8 = 8'(r_sync2);
  assign w_rise8 = 8'(r_sync2 & ~r_sync3);
  assign w_req   = r_irr & ~r_imr & VALID_MASK;

  irq_prio8 u_prio_req (
    .i_vec   (w_req),
    .o_valid (w_req_v),
    .o_idx   (w_win)
  );

  irq_prio8 u_prio_isr (
    .i_vec   (r_isr),
    .o_valid (w_isr_v),
    .o_idx   (w_isr_idx)
  );

  assign w_elig = w_req_v && (!w_isr_v || (w_win < w_isr_idx));

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wb_cyc_i && (wb_stb_i || inta_stb_i)) begin
          w_state_nxt = ST_ACK;
          w_commit    = 1'b1;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // INTA wins over a register strobe presented in the same cycle.
  assign w_inta    = w_commit && inta_stb_i;
  assign w_wr      = w_commit && !inta_stb_i && wb_we_i;
  assign w_ack_set = w_inta && w_elig;
  assign w_set8    = w_ack_set ? (8'h01 << w_win) : 8'h00;

  always_comb begin
    w_dat_nxt = r_dat;
    if (w_inta) begin
      w_dat_nxt = w_elig ? rst_op(w_win) : rst_op(3'(SPUR_VEC));
    end else if (w_commit) begin
      w_dat_nxt = (wb_adr_i == EOI_ADR) ? r_isr : r_irr;
    end
  end

  // New edges are OR-ed in after the acknowledge clear, so a coincident edge survives.
  always_comb begin
    if (EDGE) w_irr_nxt = ((r_irr & ~w_set8) | w_rise8) & VALID_MASK;
    else      w_irr_nxt = w_sync8 & VALID_MASK;
  end

  assign w_imr_nxt = (w_wr && wb_adr_i == IRR_ADR) ? wb_dat_i : r_imr;
  assign w_isr_nxt = (((w_wr && wb_adr_i == EOI_ADR) ? (r_isr & ~wb_dat_i) : r_isr)
                      | w_set8) & VALID_MASK;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_irr   <= 8'h00;
      r_imr   <= IMR_RST;
      r_isr   <= 8'h00;
      r_dat   <= 8'h00;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_irr   <= w_irr_nxt;
      r_imr   <= w_imr_nxt;
      r_isr   <= w_isr_nxt;
      r_dat   <= w_dat_nxt;
      r_irq   <= w_elig;
    end
  end

  assign wb_ack_o = (r_state == ST_ACK);
  assign wb_dat_o = r_dat;
  assign vm_irq_o = r_irq;

endmodule

// File: tb/tb_irq_wb.sv
// Directed bench for irq_wb: a table of bus/irq operations with hand-computed
// results, followed by hand-written collision, double-ack and reset sequences.
module tb_irq_wb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb_adr;
  logic [7:0] wb_dat_in;
  logic [7:0] wb_dat_out;
  logic       wb_cyc, wb_we, wb_stb, wb_ack, inta_stb, vm_irq;
  logic [7:0] irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_wb #(.NIRQ(8), .EDGE(1'b1), .SPUR_VEC(7)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat_in),
    .wb_dat_o   (wb_dat_out),
    .wb_cyc_i   (wb_cyc),
    .wb_we_i    (wb_we),
    .wb_stb_i   (wb_stb),
    .wb_ack_o   (wb_ack),
    .inta_stb_i (inta_stb),
    .irq_i      (irq),
    .vm_irq_o   (vm_irq)
  );

  typedef enum {OP_RD, OP_WR, OP_INTA, OP_PULSE} op_e;

  typedef struct {
    op_e        op;
    logic       adr;
    logic [7:0] dat;
    logic       chk_dat;
    logic [7:0] exp_dat;
    logic       exp_irq;
  } vec_t;

  vec_t tbl[28];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    inta_stb = 1'b0;
    wb_we    = 1'b0;
    wb_adr   = 1'b0;
    wb_dat_in = 8'h00;
  endtask

  task automatic bus_op(input logic inta, input logic we, input logic adr,
                        input logic [7:0] d, output logic [7:0] rd);
    @(negedge clk);
    wb_cyc    = 1'b1;
    wb_stb    = ~inta;
    inta_stb  = inta;
    wb_we     = we;
    wb_adr    = adr;
    wb_dat_in = d;
    @(negedge clk);
    chk("ack_high", {7'd0, wb_ack}, 8'h01);
    rd = wb_dat_out;
    idle_bus();
    @(negedge clk);
    chk("ack_low", {7'd0, wb_ack}, 8'h00);
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    irq = m;
    repeat (2) @(negedge clk);
    irq = 8'h00;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;

    tbl[0]  = '{OP_RD,    1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[1]  = '{OP_RD,    1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[2]  = '{OP_PULSE, 1'b0, 8'h04, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{OP_RD,    1'b0, 8'h00, 1'b1, 8'h04, 1'b0};
    tbl[4]  = '{OP_WR,    1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[5]  = '{OP_INTA,  1'b0, 8'h00, 1'b1, 8'hD7, 1'b0};
    tbl[6]  = '{OP_RD,    1'b1, 8'h00, 1'b1, 8'h04, 1'b0};
    tbl[7]  = '{OP_WR,    1'b1, 8'h04, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{OP_PULSE, 1'b0, 8'h10, 1'b0, 8'h00, 1'b1};
    tbl[9]  = '{OP_INTA,  1'b0, 8'h00, 1'b1, 8'hE7, 1'b0};
    tbl[10] = '{OP_RD,    1'b1, 8'h00, 1'b1, 8'h10, 1'b0};
    tbl[11] = '{OP_RD,    1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[12] = '{OP_PULSE, 1'b0, 8'h40, 1'b0, 8'h00, 1'b0};
    tbl[13] = '{OP_PULSE, 1'b0, 8'h02, 1'b0, 8'h00, 1'b1};
    tbl[14] = '{OP_INTA,  1'b0, 8'h00, 1'b1, 8'hCF, 1'b0};
    tbl[15] = '{OP_RD,    1'b1, 8'h00, 1'b1, 8'h12, 1'b0};
    tbl[16] = '{OP_WR,    1'b1, 8'h02, 1'b0, 8'h00, 1'b0};
    tbl[17] = '{OP_WR,    1'b1, 8'h10, 1'b0, 8'h00, 1'b1};
    tbl[18] = '{OP_INTA,  1'b0, 8'h00, 1'b1, 8'hF7, 1'b0};
    tbl[19] = '{OP_WR,    1'b1, 8'h40, 1'b0, 8'h00, 1'b0};
    tbl[20] = '{OP_PULSE, 1'b0, 8'h08, 1'b0, 8'h00, 1'b1};
    tbl[21] = '{OP_WR,    1'b0, 8'h08, 1'b0, 8'h00, 1'b0};
    tbl[22] = '{OP_INTA,  1'b0, 8'h00, 1'b1, 8'hFF, 1'b0};
    tbl[23] = '{OP_RD,    1'b0, 8'h00, 1'b1, 8'h08, 1'b0};
    tbl[24] = '{OP_RD,    1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[25] = '{OP_WR,    1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[26] = '{OP_INTA,  1'b0, 8'h00, 1'b1, 8'hDF, 1'b0};
    tbl[27] = '{OP_WR,    1'b1, 8'h08, 1'b0, 8'h00, 1'b0};

    idle_bus();
    irq   = 8'h00;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ack", {7'd0, wb_ack}, 8'h00);
    chk("reset_dat", wb_dat_out, 8'h00);
    chk("reset_irq", {7'd0, vm_irq}, 8'h00);

    for (int i = 0; i < 28; i++) begin
      rd = 8'h00;
      case (tbl[i].op)
        OP_RD:    bus_op(1'b0, 1'b0, tbl[i].adr, 8'h00, rd);
        OP_WR:    bus_op(1'b0, 1'b1, tbl[i].adr, tbl[i].dat, rd);
        OP_INTA:  bus_op(1'b1, 1'b0, 1'b0, 8'h00, rd);
        default:  pulse(tbl[i].dat);
      endcase
      if (tbl[i].chk_dat) chk($sformatf("v%0d_dat", i), rd, tbl[i].exp_dat);
      chk($sformatf("v%0d_irq", i), {7'd0, vm_irq}, {7'd0, tbl[i].exp_irq});
    end

    // Strobe held high: one ack, one idle cycle, then a fresh ack.
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 1'b0;
    @(negedge clk);
    chk("hold_ack1", {7'd0, wb_ack}, 8'h01);
    @(negedge clk);
    chk("hold_gap", {7'd0, wb_ack}, 8'h00);
    @(negedge clk);
    chk("hold_ack2", {7'd0, wb_ack}, 8'h01);
    idle_bus();
    @(negedge clk);

    // New irq0 edge lands on the commit edge of the level-0 acknowledge.
    pulse(8'h01);
    chk("col_irq_pre", {7'd0, vm_irq}, 8'h01);
    @(negedge clk);
    irq = 8'h01;
    @(negedge clk);
    @(negedge clk);
    wb_cyc = 1'b1; inta_stb = 1'b1;
    @(negedge clk);
    chk("col_ack", {7'd0, wb_ack}, 8'h01);
    chk("col_vec", wb_dat_out, 8'hC7);
    idle_bus();
    irq = 8'h00;
    @(negedge clk);
    bus_op(1'b0, 1'b0, 1'b0, 8'h00, rd);
    chk("col_irr", rd, 8'h01);
    bus_op(1'b0, 1'b0, 1'b1, 8'h00, rd);
    chk("col_isr", rd, 8'h01);
    chk("col_irq_blk", {7'd0, vm_irq}, 8'h00);
    bus_op(1'b0, 1'b1, 1'b1, 8'h01, rd);
    chk("col_irq_eoi", {7'd0, vm_irq}, 8'h01);

    // EOI 01 presented together with an INTA of level 0.
    @(negedge clk);
    wb_cyc = 1'b1; inta_stb = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 1'b1; wb_dat_in = 8'h01;
    @(negedge clk);
    chk("eoi_col_vec", wb_dat_out, 8'hC7);
    idle_bus();
    @(negedge clk);
    bus_op(1'b0, 1'b0, 1'b1, 8'h00, rd);
    chk("eoi_col_isr", rd, 8'h01);
    bus_op(1'b0, 1'b0, 1'b0, 8'h00, rd);
    chk("eoi_col_irr", rd, 8'h00);
    bus_op(1'b0, 1'b1, 1'b1, 8'h01, rd);
    chk("eoi_col_irq", {7'd0, vm_irq}, 8'h00);

    // Reset asserted while the acknowledge is on the bus.
    pulse(8'h20);
    chk("rst_irq_pre", {7'd0, vm_irq}, 8'h01);
    @(negedge clk);
    wb_cyc = 1'b1; inta_stb = 1'b1;
    @(negedge clk);
    chk("rst_ack_in", {7'd0, wb_ack}, 8'h01);
    chk("rst_vec_in", wb_dat_out, 8'hEF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ack", {7'd0, wb_ack}, 8'h00);
    chk("rst_dat", wb_dat_out, 8'h00);
    chk("rst_irq", {7'd0, vm_irq}, 8'h00);
    rst_n = 1'b1;
    idle_bus();
    @(negedge clk);
    bus_op(1'b0, 1'b0, 1'b0, 8'h00, rd);
    chk("rst_irr", rd, 8'h00);
    bus_op(1'b0, 1'b0, 1'b1, 8'h00, rd);
    chk("rst_isr", rd, 8'h00);
    pulse(8'h02);
    chk("rst_imr_irq", {7'd0, vm_irq}, 8'h00);
    bus_op(1'b0, 1'b0, 1'b0, 8'h00, rd);
    chk("rst_irr2", rd, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_wb.md
Name: irq_wb

Overview:
- Wishbone-slave priority interrupt controller for the vm80 i8080 system. It replaces the fixed "1 ms tick -> RST 4" logic.
- Collects up to 8 peripheral requests (UART, timer, buttons) and raises the CPU `vm_irq` line.
- Answers the interrupt-acknowledge bus cycle (tag bit 4) with a RST n opcode.
- Tracks in-service levels so nested interrupts preempt only at higher priority; the handler clears its level with an EOI register write.

Parameters:
- NIRQ, 8, number of request inputs (1..8); unused bits read 0 and never request.
- EDGE, 1, 1 = rising-edge latched requests; 0 = level (pending mirrors the synchronized input).
- SPUR_VEC, 7, RST number returned when an acknowledge finds nothing eligible.

Ports:
- wb_clk_i, input, 1, system clock.
- wb_rst_n_i, input, 1, reset: synchronous, active-low.
- wb_adr_i, input, 1, register select.
- wb_dat_i, input, 8, write data.
- wb_dat_o, output, 8, read data or RST opcode.
- wb_cyc_i, input, 1, bus cycle.
- wb_we_i, input, 1, write enable.
- wb_stb_i, input, 1, register strobe.
- wb_ack_o, output, 1, acknowledge for register and acknowledge accesses.
- inta_stb_i, input, 1, interrupt-acknowledge strobe (decoded from tag bit 4 by the top level).
- irq_i, input, NIRQ, asynchronous peripheral requests; bit 0 has the highest priority.
- vm_irq_o, output, 1, interrupt request to the CPU.

Behaviour:
- Input sync: 2-flop synchronizer per `irq_i` bit. In edge mode a rising edge is detected on the synchronized value (third flop).
- Registers:
  - IRR (pending), reset 0.
  - IMR (mask, 1 = masked), reset 8'hFF.
  - ISR (in-service), reset 0.
- Register map:
  - adr 0: read returns IRR; write loads IMR.
  - adr 1: read returns ISR; write is EOI, clearing every ISR bit written as 1.
- Eligibility:
  - req = IRR & ~IMR.
  - win = lowest-index set bit of req.
  - Eligible if win exists and its index < lowest-index set bit of ISR (or ISR = 0).
- vm_irq_o: registered, equal to "eligible" one cycle late. Reset value 0.
- Bus FSM, states IDLE and ACK:
  - IDLE -> ACK when wb_cyc_i & (wb_stb_i | inta_stb_i).
  - ACK: wb_ack_o = 1 for exactly one cycle, then -> IDLE.
  - Fixed 1 wait state; ACK is left unconditionally, so no double-ack even if strobe stays high.
- Data and commit timing: wb_dat_o is registered on the IDLE->ACK edge, so data is valid while ack = 1. Writes and the acknowledge commit happen on that same edge.
- Acknowledge (inta_stb_i has priority over wb_stb_i if both are set):
  - If eligible: return {2'b11, win[2:0], 3'b111}, set ISR[win], clear IRR[win] (edge mode).
  - Otherwise (spurious): return {2'b11, SPUR_VEC[2:0], 3'b111}; no state change.
- Simultaneous events:
  - A new edge on a bit being acknowledged the same cycle leaves IRR set (set wins).
  - EOI clearing a bit the acknowledge sets the same cycle leaves ISR set (set wins).
  - A mask write does not clear IRR.
- Level mode: IRR = synchronized input each cycle; the acknowledge does not clear it, and the handler must quiet the source.
- Reset mid-transaction:
  - FSM returns to IDLE, wb_ack_o = 0, wb_dat_o = 0, vm_irq_o = 0.
  - Synchronizers, IRR and ISR cleared; IMR = FF.
- Outside ACK: wb_ack_o = 0. wb_dat_o holds its last value (don't-care to the bus mux).

Decomposition:
- Shared package `irq_pkg`:
  - register offsets IRR_ADR = 0, EOI_ADR = 1;
  - RST opcode template 8'hC7;
  - reset IMR value 8'hFF.
- One sub-module, `irq_prio8`: combinational lowest-index priority encoder (8-bit in -> valid + 3-bit index), instanced twice (req and ISR).

Test Plan:
- Reset: after release read adr 0 -> 00, adr 1 -> 00; vm_irq_o = 0, IMR = FF (an edge on irq_i[2] gives IRR = 04 but no vm_irq).
- Basic: write IMR = 00, pulse irq_i[4] -> vm_irq_o rises within 4 clocks. INTA returns E7, ack high 1 cycle after strobe. ISR = 10, IRR = 00, vm_irq_o drops next cycle.
- Nesting: with ISR = 10, pulse irq_i[6] -> no vm_irq. Pulse irq_i[1] -> vm_irq, INTA returns CF, ISR = 12. EOI write 02 -> ISR = 10, irq 6 still blocked. EOI write 10 -> vm_irq and INTA returns F7.
- Spurious: raise irq_i[3], then mask it (IMR = 08) before INTA -> INTA returns FF; IRR = 08, ISR unchanged.
- Collision: an irq_i[0] edge arriving on the acknowledge commit cycle of level 0 -> IRR bit 0 remains 1 afterward. EOI 01 coinciding with an INTA of level 0 -> ISR bit 0 = 1.
- Reset mid-cycle: assert wb_rst_n_i low during ACK -> wb_ack_o = 0 next cycle, all state at reset values, no ISR bit set.
